pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory and the register/decode path. It holds the program counter and drives the fetch address to instruction memory. It captures the returned word into an IF/ID register with a valid flag. It applies stall, sequential advance and branch/jump/jump-register redirects, flushing the wrong-path instruction on a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Rst  input  1  synchronous active-high reset.
Stall  input  1  hold PC and IF/ID contents this cycle.
Branch_taken  input  1  branch in ID resolved taken.
Branch_offset  input  16  branch immediate, word offset (instr[15:0]).
Jump  input  1  J/JAL in ID.
Jump_index  input  26  jump index (instr[25:0]).
Jump_reg  input  1  JR/JALR in ID.
Reg_target  input  32  jump-register target from register read port 1.
Inst_in  input  32  instruction memory read data for address Pc_out, combinational, same cycle.
Pc_out  output  32  fetch address to instruction memory.
Ifid_inst  output  32  captured instruction to decode.
Ifid_pc4  output  32  address of captured instruction + 4.
Ifid_valid  output  1  IF/ID holds a real instruction.
Addr_err  output  1  sticky: misaligned jump-register target seen.

Behaviour:
- Reset (Rst=1 at an edge): Pc_out=RESET_PC, Ifid_inst=0, Ifid_pc4=0, Ifid_valid=0, Addr_err=0. Rst overrides all other inputs. Asserting it mid-stall or mid-redirect discards everything.
- Redirect inputs are qualified by Ifid_valid. With Ifid_valid=0 they are ignored.
- Redirect priority: Jump_reg > Jump > Branch_taken. Targets:
  - branch = Ifid_pc4 + (sign_extend(Branch_offset) << 2), modulo 2^32.
  - jump = {Ifid_pc4[31:28], Jump_index, 2'b00}.
  - jr = {Reg_target[31:2], 2'b00}. If Reg_target[1:0] != 0, Addr_err is set and stays set until reset.
- Per-edge update, first matching rule wins:
  1. Rst: as above.
  2. Qualified redirect: PC <= target. Ifid_valid <= 0 and Ifid_inst <= 0 (flush the wrong-path fetch). Ifid_pc4 <= 0. This rule takes effect even when Stall=1.
  3. Stall=1: PC, Ifid_inst, Ifid_pc4 and Ifid_valid hold their values.
  4. Normal: Ifid_inst <= Inst_in, Ifid_pc4 <= Pc_out+4, Ifid_valid <= 1, PC <= Pc_out+4.
- Latency:
  - An instruction at address A appears on Ifid_inst one edge after Pc_out=A.
  - A redirect costs exactly one bubble cycle (Ifid_valid=0), followed by the target instruction.
- Width rules:
  - PC+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
  - Pc_out[1:0] is always 0.
  - Ifid_pc4 uses the same wrapping add.
- No combinational path from Inst_in to any output. Pc_out is a pure register output.
- Back-to-back redirects cannot occur: the cycle after a redirect has Ifid_valid=0, so redirect inputs are ignored.

Test Plan:
1. Reset release with RESET_PC=0 and memory word n = 32'h1000_0000+n, no stall -> Pc_out 0,4,8,... The cycle after the first edge shows Ifid_inst=32'h1000_0000, Ifid_pc4=4, Ifid_valid=1.
2. Stall=1 for 3 cycles while Pc_out=8 -> Pc_out stays 8 and IF/ID stays unchanged. After release, fetch resumes at 8 with no skipped or duplicated word.
3. Branch_taken with Ifid_pc4=32'h0000_0010 and Branch_offset=16'hFFFC -> Pc_out=32'h0000_0000 next cycle, one cycle with Ifid_valid=0, then the word at address 0. Repeat with Stall=1 asserted in the same cycle: same result, because the redirect wins.
4. Jump=1, Jump_reg=1 and Branch_taken=1 together, Reg_target=32'h0000_0403 -> Pc_out=32'h0000_0400 and Addr_err=1. Addr_err stays 1 after later normal fetches; Rst clears it.
5. Jump with Ifid_pc4=32'hA000_0004 and Jump_index=26'h0000100 -> Pc_out=32'hA000_0400. Separately, with Pc_out=32'hFFFF_FFFC and a normal advance -> Pc_out=0 and Ifid_pc4=0.
6. Assert Rst during a stall and during a redirect cycle -> next cycle Pc_out=RESET_PC, Ifid_valid=0, Ifid_inst=0, Addr_err=0. Redirect inputs with Ifid_valid=0 produce no PC change.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: redirect controls in, instruction memory
// and IF/ID register contents out.
interface pc_fetch_unit_if;
  logic        Stall;
  logic        Branch_taken;
  logic [15:0] Branch_offset;
  logic        Jump;
  logic [25:0] Jump_index;
  logic        Jump_reg;
  logic [31:0] Reg_target;
  logic [31:0] Inst_in;
  logic [31:0] Pc_out;
  logic [31:0] Ifid_inst;
  logic [31:0] Ifid_pc4;
  logic        Ifid_valid;
  logic        Addr_err;

  modport master (
    output Stall, Branch_taken, Branch_offset,
    output Jump, Jump_index, Jump_reg, Reg_target,
    output Inst_in,
    input  Pc_out, Ifid_inst, Ifid_pc4,
    input  Ifid_valid, Addr_err
  );

  modport slave (
    input  Stall, Branch_taken, Branch_offset,
    input  Jump, Jump_index, Jump_reg, Reg_target,
    input  Inst_in,
    output Pc_out, Ifid_inst, Ifid_pc4,
    output Ifid_valid, Addr_err
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register,
// stall handling and branch/jump/jr redirect with flush.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            Clk,
  input  logic            Rst,
  pc_fetch_unit_if.slave  bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] redir_tgt;
  logic        redir;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc4_q + {{14{bus.Branch_offset[15]}},
                             bus.Branch_offset, 2'b00};
  assign j_tgt    = {pc4_q[31:28], bus.Jump_index, 2'b00};
  assign jr_tgt   = {bus.Reg_target[31:2], 2'b00};

  // Redirects only count when ID holds a real instruction
  assign redir = valid_q &
                 (bus.Jump_reg | bus.Jump | bus.Branch_taken);

  always_comb begin
    redir_tgt = br_tgt;
    if (bus.Jump_reg)
      redir_tgt = jr_tgt;
    else if (bus.Jump)
      redir_tgt = j_tgt;
  end

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (redir) begin
      pc_d    = redir_tgt;
      inst_d  = 32'd0;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      if (bus.Jump_reg && bus.Reg_target[1:0] != 2'b00)
        err_d = 1'b1;
    end else if (!bus.Stall) begin
      pc_d    = pc_plus4;
      inst_d  = bus.Inst_in;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.Pc_out     = pc_q;
  assign bus.Ifid_inst  = inst_q;
  assign bus.Ifid_pc4   = pc4_q;
  assign bus.Ifid_valid = valid_q;
  assign bus.Addr_err   = err_q;

endmodule
